// File: rtl/buffer_pkg.sv
// ============================================================================
// Module   : buffer_pkg
// Brief    : Shared constants and helpers for the sync_buffer delay line.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package buffer_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_DEPTH = 1;
    localparam int MAX_DEPTH     = 64;

    // Bits needed to hold values 0..value-1 (minimum 1 once value >= 2).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/buffer_stage.sv
// ============================================================================
// Module   : buffer_stage
// Brief    : One WIDTH-bit register stage with async active-low reset value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module buffer_stage
    import buffer_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

`default_nettype wire

// File: rtl/sync_buffer.sv
// ============================================================================
// Module   : sync_buffer
// Brief    : Fixed-latency delay line of DEPTH stages with a fill flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_buffer
    import buffer_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             primed
);

    localparam int                 c_cnt_w = clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_depth_check
        $error("sync_buffer: DEPTH=%0d outside 1..%0d", DEPTH, MAX_DEPTH);
    end

    logic [WIDTH-1:0] stage_q [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] stage_d;

        if (k == 0) begin : g_head
            assign stage_d = in;
        end else begin : g_link
            assign stage_d = stage_q[k-1];
        end

        buffer_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (stage_d),
            .q     (stage_q[k])
        );
    end

    assign out = stage_q[DEPTH-1];

    // Fill counter: counts post-reset edges and saturates once the chain is full.
    logic [c_cnt_w-1:0] count_d;
    logic [c_cnt_w-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (count_q != c_full) begin
            count_d = count_q + c_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign primed = (count_q == c_full);

endmodule

`default_nettype wire

// File: tb/tb_sync_buffer.sv
// ============================================================================
// Module   : tb_sync_buffer
// Brief    : Scoreboard bench for three sync_buffer configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_buffer;

    typedef struct packed {
        logic       a_out;
        logic       a_pr;
        logic [7:0] b_out;
        logic       b_pr;
        logic [7:0] c_out;
        logic       c_pr;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] in8;
    logic [7:0] in_late;
    logic       use_late;
    wire  [7:0] in_bus = use_late ? in_late : in8;

    logic       a_out;
    logic       a_pr;
    logic [7:0] b_out;
    logic       b_pr;
    logic [7:0] c_out;
    logic       c_pr;

    int total = 0;
    int bad   = 0;

    logic [7:0] hist [$];
    exp_t       exp_q [$];

    sync_buffer u_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in_bus[0]),
        .out    (a_out),
        .primed (a_pr)
    );

    sync_buffer #(.WIDTH(8), .DEPTH(4)) u_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in_bus),
        .out    (b_out),
        .primed (b_pr)
    );

    sync_buffer #(.WIDTH(8), .DEPTH(2), .RESET_VAL(8'hA5)) u_c (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in_bus),
        .out    (c_out),
        .primed (c_pr)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Reference: output is the word captured d edges ago, or the reset value
    // while fewer than d words have been captured since reset.
    function automatic logic [7:0] exp_out(input int d, input logic [7:0] rv);
        if (hist.size() >= d) return hist[hist.size() - d];
        return rv;
    endfunction

    function automatic exp_t model_now();
        exp_t       e;
        logic [7:0] t;
        t       = exp_out(1, 8'h00);
        e.a_out = t[0];
        e.a_pr  = (hist.size() >= 1);
        e.b_out = exp_out(4, 8'h00);
        e.b_pr  = (hist.size() >= 4);
        e.c_out = exp_out(2, 8'hA5);
        e.c_pr  = (hist.size() >= 2);
        return e;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare(input string tag, input exp_t e);
        chk({tag, " a_out"},  {7'b0, a_out}, {7'b0, e.a_out});
        chk({tag, " a_prim"}, {7'b0, a_pr},  {7'b0, e.a_pr});
        chk({tag, " b_out"},  b_out,         e.b_out);
        chk({tag, " b_prim"}, {7'b0, b_pr},  {7'b0, e.b_pr});
        chk({tag, " c_out"},  c_out,         e.c_out);
        chk({tag, " c_prim"}, {7'b0, c_pr},  {7'b0, e.c_pr});
    endtask

    // Called at each rising edge: record what the DUTs capture there.
    task automatic model_edge();
        if (!rst_n) hist.delete();
        else        hist.push_back(in_bus);
        exp_q.push_back(model_now());
    endtask

    task automatic step(input logic [7:0] v);
        in8 = v;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Entered 1 time unit after an edge; drops reset mid-cycle.
    task automatic pulse_reset();
        #5;
        rst_n = 1'b0;
        hist.delete();
        #1;
        compare("async_rst", model_now());
        @(posedge clk);
        model_edge();
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) compare("edge", exp_q.pop_front());
    end

    initial begin
        rst_n    = 1'b1;
        in8      = 8'h00;
        in_late  = 8'h00;
        use_late = 1'b0;
        #1 rst_n = 1'b0;
        #1 compare("reset", model_now());

        repeat (3) begin
            @(posedge clk);
            model_edge();
            #1 in8 = ~in8;
        end
        rst_n = 1'b1;

        step(8'h00); step(8'h01); step(8'h00); step(8'h01);

        pulse_reset();
        for (int i = 1; i <= 10; i++) step(8'(i));

        pulse_reset();
        for (int i = 0; i < 6; i++) step(8'h40 + 8'(i));

        // Change coincident with an edge must land on the following edge.
        in8      = 8'h3C;
        in_late  = 8'h3C;
        use_late = 1'b1;
        @(posedge clk);
        model_edge();
        in_late <= 8'hC3;
        #1;
        in8      = 8'hC3;
        use_late = 1'b0;
        @(posedge clk);
        model_edge();
        #1;

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) pulse_reset();
            else                            step(8'($urandom));
        end

        repeat (2) @(negedge clk);
        #1;
        chk("drain", 8'(exp_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sync_buffer.md
# sync_buffer

Clocked delay-line buffer: registers a `WIDTH`-bit input and presents it at the output exactly `DEPTH` rising clock edges later. It sits on signal paths that need retiming or fixed-latency alignment. It also drives a status flag showing when the pipeline holds only post-reset data. The default configuration (`WIDTH=1`, `DEPTH=1`) is a single-bit, one-cycle register buffer.

## Interface
- `WIDTH`, default 1: data width in bits, ≥1.
- `DEPTH`, default 1: number of register stages (latency in cycles), 1..64.
- `RESET_VAL`, default all-zero: value loaded into every stage on reset, `WIDTH` bits.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `in`  input  `WIDTH`  data to be buffered.
- `out`  output  `WIDTH`  `in` delayed by `DEPTH` cycles; driven directly from the last stage register.
- `primed`  output  1  high once `DEPTH` edges have elapsed since reset release.

## Operation
- Stages `s[0]..s[DEPTH-1]` form a shift chain.
  - On each rising `clk` edge with `rst_n=1`: `s[0] <= in` and `s[k] <= s[k-1]` for k ≥ 1.
  - `out = s[DEPTH-1]`. No combinational path from `in` to `out`.
- `primed` is driven by a fill counter of width `clog2(DEPTH+1)`.
  - The counter increments on each edge while below `DEPTH`, then saturates.
  - `primed = (count == DEPTH)`.
- Reset:
  - `rst_n=0` immediately clears every stage to `RESET_VAL`, clears the counter, and forces `primed=0`, independent of `clk`.
  - Asserting reset mid-stream discards all in-flight data.
- No enable and no flush: data shifts every cycle.
- `DEPTH` outside 1..64 is an elaboration error (static assertion).

## Timing
- Latency: a value present on `in` at rising edge N appears on `out` just after edge N+`DEPTH-1`.
  - With `DEPTH=1`, `out` shows edge-N data for the cycle following edge N.
- `in` is sampled at the rising edge. A change coincident with an edge is treated as arriving after that edge and is captured on the next edge.
- Reset release:
  - The first capture is the first rising edge with `rst_n=1`.
  - `primed` rises after the `DEPTH`-th such edge.
- Reset values: `out=RESET_VAL`, `primed=0`.
- Throughput: one word per cycle, continuous.

## Structure
- Shared package `buffer_pkg`:
  - default `WIDTH` and `DEPTH` constants.
  - `MAX_DEPTH=64`.
  - `clog2` helper function.
- Natural sub-module: `buffer_stage`, a single `WIDTH`-bit register with async active-low reset to `RESET_VAL`.
  - Instantiated `DEPTH` times via a generate loop and chained.
- The fill counter and the `primed` compare live in the top level.

## Test plan
Clock period 10 ns, `clk` starts high.
1. Reset hold: `rst_n=0` for 3 cycles with `in` toggling -> `out=0` and `primed=0` throughout.
2. Default config, `in` driven 0,1,0,1 changing at each rising edge (t=10, 20, 30) after reset release -> `out` reproduces 0,1,0,1 one cycle behind; `primed=1` after the first edge.
3. `DEPTH=4`, `WIDTH=8`, `in` incrementing 0x01,0x02,… each cycle -> `out` shows 0x00 for the first 4 edges, then 0x01,0x02,… in order; `primed` rises at edge 4.
4. Async reset mid-stream (`DEPTH=4`): drop `rst_n` between edges while non-zero data is in flight -> `out` and `primed` go to 0 immediately, without waiting for an edge; after release, old data never reappears.
5. `RESET_VAL=8'hA5`, `DEPTH=2`: during reset `out=0xA5`; after release `out` stays 0xA5 for 2 edges, then shows captured data.
6. Coincident change: `in` changes exactly at a rising edge -> the new value is captured on the following edge, not the current one.
